// File: rtl/ibex_instr_mem_responder_pkg.sv
// Shared types and parameter checks for the instruction-side memory responder.
package ibex_instr_mem_pkg;

    localparam int unsigned MaxLatency = 4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_stage_t;

    function automatic bit params_ok(int unsigned mem_words, int unsigned latency,
                                     int unsigned max_out);
        return (mem_words >= 4) && ((mem_words & (mem_words - 1)) == 0) &&
               (latency >= 1) && (latency <= MaxLatency) &&
               (max_out >= 1) && (max_out <= latency);
    endfunction

endpackage

// File: rtl/ibex_instr_mem_responder_if.sv
// req/gnt/rvalid instruction fetch bus between the prefetcher (master) and responder (slave).
interface ibex_instr_mem_responder_if;

    logic        instr_req;
    logic        instr_gnt;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    modport master (
        output instr_req, instr_addr,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err
    );

endinterface

// File: rtl/ibex_instr_mem_responder_ram.sv
// Word-addressed instruction RAM: one synchronous read port, one write port,
// read-before-write on a same-word collision.
module ibex_instr_mem_ram #(
    parameter int unsigned MemWords = 1024,
    parameter int unsigned AddrW    = $clog2(MemWords)
) (
    input  logic             clk_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [31:0]      rdata_o,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [31:0]      wdata_i
);

    logic [31:0] mem [MemWords];

    // Non-blocking update makes a colliding read see the pre-write word.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Terminates the instruction fetch bus: gated grants, fixed-latency in-order
// responses from the internal RAM, and bus errors for out-of-range words.
module ibex_instr_mem_responder
    import ibex_instr_mem_pkg::*;
#(
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    ibex_instr_mem_responder_if.slave    bus,
    input  logic                         stall_i,
    input  logic                         load_we_i,
    input  logic [31:0]                  load_addr_i,
    input  logic [31:0]                  load_wdata_i,
    output logic                         busy_o
);

    localparam int unsigned    AddrW  = $clog2(MemWords);
    localparam int unsigned    CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    if (!params_ok(MemWords, Latency, MaxOutstanding)) begin : g_bad_params
        $fatal(1, "ibex_instr_mem_responder: illegal MemWords/Latency/MaxOutstanding");
    end

    logic [CntW-1:0] count_q;
    logic            gnt;
    logic            rvalid;
    logic [29:0]     widx;
    logic            req_err;
    logic            head_vld_q;
    logic            head_err_q;
    logic [31:0]     ram_rdata;
    resp_stage_t     stage [Latency];
    logic            unused_addr_bits;

    assign widx    = bus.instr_addr[31:2];
    assign req_err = {2'b00, widx} >= 32'(MemWords);
    assign rvalid  = stage[Latency-1].valid;

    // A slot retiring this cycle is immediately reusable, hence the rvalid term.
    assign gnt = bus.instr_req & ~stall_i & ~rst_i & ((count_q < MaxCnt) | rvalid);

    ibex_instr_mem_ram #(
        .MemWords (MemWords),
        .AddrW    (AddrW)
    ) u_ram (
        .clk_i   (clk_i),
        .re_i    (gnt),
        .raddr_i (widx[AddrW-1:0]),
        .rdata_o (ram_rdata),
        .we_i    (load_we_i),
        .waddr_i (load_addr_i[AddrW+1:2]),
        .wdata_i (load_wdata_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_vld_q <= 1'b0;
            head_err_q <= 1'b0;
        end else begin
            head_vld_q <= gnt;
            head_err_q <= gnt & req_err;
        end
    end

    // Stage 0 is the RAM output register; stale RAM data is masked out here.
    for (genvar s = 0; s < Latency; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign stage[0] = '{valid: head_vld_q,
                                err:   head_err_q,
                                rdata: (head_vld_q & ~head_err_q) ? ram_rdata : 32'h0};
        end else begin : g_shift
            resp_stage_t stage_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) stage_q <= '0;
                else       stage_q <= stage[s-1];
            end
            assign stage[s] = stage_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            unique case ({gnt, rvalid})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign busy_o           = (count_q != '0) & ~rst_i;
    assign bus.instr_gnt    = gnt;
    assign bus.instr_rvalid = rvalid;
    assign bus.instr_rdata  = stage[Latency-1].rdata;
    assign bus.instr_err    = stage[Latency-1].err;

    assign unused_addr_bits = ^{bus.instr_addr[1:0], load_addr_i[1:0], load_addr_i[31:AddrW+2]};

    a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i) count_q <= MaxCnt);

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench: three responder configurations, a scoreboard on every response and
// a vector table plus hand sequences for the timing corner cases.
module tb_ibex_instr_mem_responder;

    localparam int N = 3;
    localparam int LAT [N] = '{1, 3, 4};
    localparam int MO  [N] = '{1, 1, 2};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        stall;
        logic        lwe;
        logic [31:0] laddr;
        logic [31:0] lwdata;
        logic        eg;
        logic        erv;
        logic [31:0] edata;
        logic        eerr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst    [N];
    logic        req    [N];
    logic        stall  [N];
    logic        lwe    [N];
    logic [31:0] addr   [N];
    logic [31:0] laddr  [N];
    logic [31:0] lwdata [N];
    logic        gnt    [N];
    logic        rvalid [N];
    logic        err    [N];
    logic        busy   [N];
    logic [31:0] rdata  [N];

    logic        obs_gnt   [N];
    logic        obs_rv    [N];
    logic        obs_err   [N];
    logic        obs_busy  [N];
    logic [31:0] obs_rdata [N];

    exp_t        sb    [N][$];
    logic [31:0] model [N][1024];
    vec_t        tbl   [$];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        ibex_instr_mem_responder_if bif ();
        assign bif.instr_req  = req[g];
        assign bif.instr_addr = addr[g];
        assign gnt[g]    = bif.instr_gnt;
        assign rvalid[g] = bif.instr_rvalid;
        assign rdata[g]  = bif.instr_rdata;
        assign err[g]    = bif.instr_err;

        ibex_instr_mem_responder #(
            .MemWords       (1024),
            .Latency        (LAT[g]),
            .MaxOutstanding (MO[g])
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst[g]),
            .bus          (bif),
            .stall_i      (stall[g]),
            .load_we_i    (lwe[g]),
            .load_addr_i  (laddr[g]),
            .load_wdata_i (lwdata[g]),
            .busy_o       (busy[g])
        );
    end

    task automatic chk(input bit ok, input string name, input logic [35:0] act,
                       input logic [35:0] exp);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] pre(int w);
        case (w)
            0:       return 32'h11;
            1:       return 32'h22;
            2:       return 32'h33;
            8:       return 32'hAAAA;
            default: return 32'hC0DE_0000 | 32'(w);
        endcase
    endfunction

    function automatic vec_t v(logic rq, logic [31:0] a, logic st, logic we, logic [31:0] la,
                               logic [31:0] wd, logic eg, logic erv, logic [31:0] ed, logic ee);
        vec_t r;
        r.req = rq; r.addr = a; r.stall = st; r.lwe = we; r.laddr = la; r.lwdata = wd;
        r.eg = eg; r.erv = erv; r.edata = ed; r.eerr = ee;
        return r;
    endfunction

    // Sampled at the falling edge: scoreboard pop/push, then the reference RAM update.
    task automatic monitor();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            obs_gnt[i] = gnt[i]; obs_rv[i] = rvalid[i]; obs_err[i] = err[i];
            obs_busy[i] = busy[i]; obs_rdata[i] = rdata[i];
            if (rst[i]) begin
                sb[i].delete();
                chk(gnt[i] == 1'b0 && busy[i] == 1'b0, "reset_gnt_busy",
                    36'({gnt[i], busy[i]}), 36'h0);
            end else begin
                chk(busy[i] == (sb[i].size() != 0), "busy_vs_outstanding",
                    36'(busy[i]), 36'(sb[i].size() != 0));
                if (rvalid[i]) begin
                    chk(sb[i].size() != 0, "rvalid_unexpected", 36'(rdata[i]), 36'h0);
                    if (sb[i].size() != 0) begin
                        e = sb[i].pop_front();
                        chk(rdata[i] == e.rdata && err[i] == e.err && cyc == e.due, "sb_response",
                            {3'b0, err[i], rdata[i]}, {3'b0, e.err, e.rdata});
                    end
                end else begin
                    chk(rdata[i] == 32'h0 && err[i] == 1'b0, "idle_response_zero",
                        {3'b0, err[i], rdata[i]}, 36'h0);
                end
                if (gnt[i]) begin
                    chk(req[i] == 1'b1, "gnt_without_req", 36'(gnt[i]), 36'h0);
                    e.err   = |addr[i][31:12];
                    e.rdata = e.err ? 32'h0 : model[i][addr[i][11:2]];
                    e.due   = cyc + LAT[i];
                    sb[i].push_back(e);
                end
            end
            if (lwe[i]) model[i][laddr[i][11:2]] = lwdata[i];
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b0; stall[i] = 1'b0; lwe[i] = 1'b0;
            addr[i] = 32'h0; laddr[i] = 32'h0; lwdata[i] = 32'h0;
        end
    endtask

    initial begin
        bit eg_b [7];
        bit erv_b [7];
        bit eg_c [6];
        int ngr;

        for (int i = 0; i < N; i++) rst[i] = 1'b1;
        idle_all();
        @(posedge clk);
        #1;

        // Preload during reset: the RAM is not reset and the load port stays live.
        for (int w = 0; w < 16; w++) begin
            for (int i = 0; i < N; i++) begin
                lwe[i] = 1'b1; laddr[i] = 32'(w * 4); lwdata[i] = pre(w);
            end
            step();
        end
        idle_all();
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        step();
        for (int i = 0; i < N; i++)
            chk(!obs_gnt[i] && !obs_rv[i] && !obs_busy[i], "post_reset_state",
                36'({obs_gnt[i], obs_rv[i], obs_busy[i]}), 36'h0);

        // Instance 0: Latency=1, MaxOutstanding=1.
        tbl.push_back(v(1, 32'h0,        0, 0, 0,           0,            1, 0, 32'h0,        0));
        tbl.push_back(v(1, 32'h4,        0, 0, 0,           0,            1, 1, 32'h11,       0));
        tbl.push_back(v(1, 32'h8,        0, 0, 0,           0,            1, 1, 32'h22,       0));
        tbl.push_back(v(0, 32'h0,        0, 0, 0,           0,            0, 1, 32'h33,       0));
        tbl.push_back(v(0, 32'h0,        0, 0, 0,           0,            0, 0, 32'h0,        0));
        tbl.push_back(v(1, 32'h10,       1, 0, 0,           0,            0, 0, 32'h0,        0));
        tbl.push_back(v(1, 32'h10,       1, 0, 0,           0,            0, 0, 32'h0,        0));
        tbl.push_back(v(1, 32'h10,       1, 0, 0,           0,            0, 0, 32'h0,        0));
        tbl.push_back(v(1, 32'h10,       0, 0, 0,           0,            1, 0, 32'h0,        0));
        tbl.push_back(v(0, 32'h0,        0, 0, 0,           0,            0, 1, 32'hC0DE0004, 0));
        tbl.push_back(v(1, 32'h1000,     0, 0, 0,           0,            1, 0, 32'h0,        0));
        tbl.push_back(v(1, 32'hC,        0, 0, 0,           0,            1, 1, 32'h0,        1));
        tbl.push_back(v(0, 32'h0,        0, 0, 0,           0,            0, 1, 32'hC0DE0003, 0));
        tbl.push_back(v(1, 32'hFFFFFFFC, 0, 0, 0,           0,            1, 0, 32'h0,        0));
        tbl.push_back(v(0, 32'h0,        0, 0, 0,           0,            0, 1, 32'h0,        1));
        tbl.push_back(v(0, 32'h0,        0, 1, 32'hFFC,     32'h12345678, 0, 0, 32'h0,        0));
        tbl.push_back(v(1, 32'hFFC,      0, 0, 0,           0,            1, 0, 32'h0,        0));
        tbl.push_back(v(0, 32'h0,        0, 0, 0,           0,            0, 1, 32'h12345678, 0));
        tbl.push_back(v(0, 32'h0,        0, 1, 32'h1024,    32'h9999,     0, 0, 32'h0,        0));
        tbl.push_back(v(1, 32'h24,       0, 0, 0,           0,            1, 0, 32'h0,        0));
        tbl.push_back(v(0, 32'h0,        0, 0, 0,           0,            0, 1, 32'h9999,     0));
        tbl.push_back(v(1, 32'h20,       0, 1, 32'h20,      32'hBBBB,     1, 0, 32'h0,        0));
        tbl.push_back(v(1, 32'h20,       0, 0, 0,           0,            1, 1, 32'hAAAA,     0));
        tbl.push_back(v(0, 32'h0,        0, 0, 0,           0,            0, 1, 32'hBBBB,     0));
        tbl.push_back(v(0, 32'h0,        0, 0, 0,           0,            0, 0, 32'h0,        0));

        foreach (tbl[k]) begin
            req[0] = tbl[k].req; addr[0] = tbl[k].addr; stall[0] = tbl[k].stall;
            lwe[0] = tbl[k].lwe; laddr[0] = tbl[k].laddr; lwdata[0] = tbl[k].lwdata;
            step();
            chk(obs_gnt[0] == tbl[k].eg && obs_rv[0] == tbl[k].erv &&
                obs_err[0] == tbl[k].eerr && obs_rdata[0] == tbl[k].edata,
                $sformatf("vec%0d {gnt,rv,err,0,rdata}", k),
                {obs_gnt[0], obs_rv[0], obs_err[0], 1'b0, obs_rdata[0]},
                {tbl[k].eg, tbl[k].erv, tbl[k].eerr, 1'b0, tbl[k].edata});
        end
        idle_all();

        // Instance 1: Latency=3, MaxOutstanding=1 -- second grant waits for the first rvalid.
        eg_b  = '{1, 0, 0, 1, 0, 0, 0};
        erv_b = '{0, 0, 0, 1, 0, 0, 1};
        ngr = 0;
        req[1] = 1'b1; addr[1] = 32'h0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk(obs_gnt[1] == eg_b[k] && obs_rv[1] == erv_b[k], $sformatf("limit_k%0d {gnt,rv}", k),
                36'({obs_gnt[1], obs_rv[1]}), 36'({eg_b[k], erv_b[k]}));
            if (obs_gnt[1]) begin
                ngr++;
                addr[1] = addr[1] + 32'h4;
                if (ngr == 2) req[1] = 1'b0;
            end
        end
        idle_all();

        // Instance 2: Latency=4, MaxOutstanding=2 -- reset with two requests in flight.
        req[2] = 1'b1; addr[2] = 32'h0;
        step();
        chk(obs_gnt[2] == 1'b1, "rst_first_gnt", 36'(obs_gnt[2]), 36'h1);
        addr[2] = 32'h4;
        step();
        chk(obs_gnt[2] == 1'b1 && obs_busy[2] == 1'b1, "rst_second_gnt_busy",
            36'({obs_gnt[2], obs_busy[2]}), 36'h3);
        req[2] = 1'b0; rst[2] = 1'b1;
        step();
        chk(!obs_rv[2] && !obs_busy[2], "rst_cycle_quiet", 36'({obs_rv[2], obs_busy[2]}), 36'h0);
        rst[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk(!obs_rv[2] && !obs_busy[2], $sformatf("rst_discard_k%0d", k),
                36'({obs_rv[2], obs_busy[2]}), 36'h0);
        end
        req[2] = 1'b1; addr[2] = 32'h8;
        step();
        chk(obs_gnt[2] == 1'b1, "post_rst_gnt", 36'(obs_gnt[2]), 36'h1);
        req[2] = 1'b0;
        for (int k = 0; k < 3; k++) step();
        step();
        chk(obs_rv[2] && obs_rdata[2] == 32'h33 && !obs_err[2], "post_rst_resp",
            {3'b0, obs_rv[2], obs_rdata[2]}, {3'b0, 1'b1, 32'h33});

        // Instance 2 throughput: two grants per four cycles, reuse on the retiring cycle.
        eg_c = '{1, 1, 0, 0, 1, 1};
        req[2] = 1'b1; addr[2] = 32'h10;
        for (int k = 0; k < 6; k++) begin
            step();
            chk(obs_gnt[2] == eg_c[k], $sformatf("thru_k%0d gnt", k), 36'(obs_gnt[2]), 36'(eg_c[k]));
            if (obs_gnt[2]) addr[2] = addr[2] + 32'h4;
        end
        idle_all();

        for (int k = 0; k < 8; k++) step();
        for (int i = 0; i < N; i++)
            chk(sb[i].size() == 0, $sformatf("drain_inst%0d", i), 36'(sb[i].size()), 36'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_instr_mem_responder.md
# ibex_instr_mem_responder

Instruction-side memory responder that terminates the core's req/gnt/rvalid instruction fetch bus. It grants fetch requests subject to an outstanding-request limit and an external stall input. It returns read data from an internal word-addressed RAM after a fixed, parameterised latency, strictly in order, and flags out-of-range accesses as bus errors. It sits between the prefetch logic and the instruction storage, for simulation and FPGA builds, and is also the bench's reference bus slave.

## Interface
- MemWords, 1024: RAM depth in 32-bit words; must be a power of two ≥ 4.
- Latency, 1: cycles from grant to rvalid; legal range 1..4.
- MaxOutstanding, 2: maximum granted-but-unanswered requests; legal range 1..Latency.

- clk_i  in  1  clock; all logic rising-edge.
- rst_i  in  1  reset; synchronous, active-high.
- instr_req_i  in  1  fetch request.
- instr_gnt_o  out  1  request accepted this cycle.
- instr_addr_i  in  32  byte address; bits [1:0] ignored.
- instr_rvalid_o  out  1  response valid.
- instr_rdata_o  out  32  response data.
- instr_err_o  out  1  response is a bus error.
- stall_i  in  1  suppresses grants, for back-pressure injection.
- load_we_i  in  1  RAM write enable.
- load_addr_i  in  32  byte address for load; bits [1:0] ignored.
- load_wdata_i  in  32  load data.
- busy_o  out  1  one or more requests outstanding.

## Operation
- **Grant.** instr_gnt_o = instr_req_i & ~stall_i & ~rst_i & (count_q < MaxOutstanding | instr_rvalid_o).
  - A slot retiring in the same cycle may be reused.
  - Grant is combinational from registered state plus req/stall. There is no path from instr_addr_i.
- **Sampling.** The address is sampled only in the cycle instr_gnt_o=1. The requester holds req and addr until granted. The responder does not check this.
- **Word index.** widx = instr_addr_i[31:2].
  - err = (widx ≥ MemWords).
  - The RAM is read with widx modulo MemWords. Its output is replaced by 0 when err=1.
- **Response pipeline.** Latency stages, each holding {valid, err, rdata}.
  - Stage 0 is loaded on grant from the synchronous RAM read.
  - Each stage shifts forward every cycle. There is no stalling; the requester must always accept rvalid.
  - Last stage drives instr_rvalid_o, instr_rdata_o and instr_err_o.
  - When valid=0, rdata_o and err_o are 0.
- **Outstanding counter.**
  - count_d = count_q + gnt − rvalid.
  - Width $clog2(MaxOutstanding+1).
  - Never overflows, because grant is gated. Never underflows, because rvalid only comes from granted entries.
  - busy_o = (count_q != 0).
- **Load port.** One write per cycle: RAM[load_addr_i[31:2] mod MemWords] ← load_wdata_i.
  - A same-cycle read and write to the same word returns the old data (read-before-write).
  - An out-of-range load address wraps; it raises no error.
- **Reset.** While rst_i=1:
  - all pipeline valid bits and count_q clear;
  - gnt, rvalid, rdata, err and busy are 0;
  - RAM contents are not reset.
- **Reset mid-operation.** In-flight requests are discarded and never answered. The first grant is possible in the cycle after rst_i deasserts.

## Timing
- Grant in cycle N gives rvalid in cycle N+Latency, with that request's data and error.
- Throughput is one grant per cycle when MaxOutstanding = Latency. Otherwise it is MaxOutstanding grants per Latency cycles.
- A grant in the same cycle as the rvalid that frees the slot is legal and required (no bubble).
- stall_i affects only the current cycle's grant. Responses already in flight are unaffected.
- There are no combinational paths from any input to rvalid, rdata or err.

## Structure
- Package ibex_instr_mem_pkg:
  - MaxLatency = 4;
  - resp_stage_t packed struct {logic valid; logic err; logic [31:0] rdata};
  - parameter-range check function.
- Sub-module ibex_instr_mem_ram: MemWords×32, one synchronous read port, one write port, read-before-write.
- Top level: grant logic, counter, resp_stage_t pipeline array (generate over Latency), parameter assertions.

## Test plan
- **Back-to-back reads.** Latency=1, MaxOutstanding=1; RAM[0..2] loaded with 0x11, 0x22, 0x33; req held with addr 0x0, 0x4, 0x8 advancing on each grant → gnt in cycles 1, 2, 3; rvalid in cycles 2, 3, 4 with 0x11, 0x22, 0x33; err=0.
- **Outstanding limit.** Latency=3, MaxOutstanding=1; req 0x0 then 0x4 → first gnt cycle 1; gnt low cycles 2–3; second gnt cycle 4 (same cycle as first rvalid); second rvalid cycle 7.
- **Out-of-range access.** addr = 4·MemWords (0x1000 at default) → gnt; rvalid Latency cycles later with err=1 and rdata=0; an in-range access immediately after returns err=0.
- **Stall injection.** stall_i=1 for 3 cycles with req=1 and addr 0x10 → gnt=0 throughout; gnt in the first cycle stall_i=0; response carries RAM[4].
- **Reset mid-operation.** Latency=4, two requests in flight; rst_i pulsed for 1 cycle → no rvalid ever appears for them; busy_o=0 in the cycle after reset; a new request after reset is granted and answered normally.
- **Load/read collision.** RAM[8]=0xAAAA; load 0xBBBB to 0x20 in the same cycle a read of 0x20 is granted → response 0xAAAA; the next read of 0x20 returns 0xBBBB.
